// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared frame constants and state type for the ADC sequencer
package adc_seq_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_HI    = 13;
    localparam int ADDR_LO    = 11;
    localparam int DATA_BITS  = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GUARD
    } seq_state_t;

endpackage

// File: rtl/adc_rr_pick.sv
// rtl/adc_rr_pick.sv - cyclic next-set-bit selector for round-robin channel scheduling
module adc_rr_pick (
    input  logic [7:0] i_mask,
    input  logic [2:0] i_last,
    output logic [2:0] o_next
);

    logic [2:0] w_idx;
    logic       w_found;

    // Walk the mask starting one past i_last; the eighth step lands on i_last itself
    always_comb begin
        o_next  = 3'd0;
        w_idx   = 3'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            w_idx = i_last + 3'(k);
            if (!w_found && i_mask[w_idx]) begin
                o_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc128_seq_ctrl.sv
// rtl/adc128_seq_ctrl.sv - ADC128S022 frame sequencer with round-robin channels and sample holding register
module adc128_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int CLK_DIV = 12,
    parameter int NUM_CH  = 8
) (
    input  logic                 clk_clk,
    input  logic                 reset_n,
    input  logic                 trigger,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic                 adc_din,
    input  logic                 adc_dout,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic [DATA_BITS-1:0] sample_data,
    output logic [2:0]           sample_ch,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] HALF_LAST = 5'(2 * FRAME_BITS - 1);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [7:0]            r_div;
    logic [4:0]            r_half;
    logic                  r_dout_s1;
    logic                  r_dout_s2;
    logic [DATA_BITS-1:0]  r_shift;
    logic [2:0]            r_next_addr;
    logic [2:0]            r_last_addr;
    logic                  r_primed;
    logic                  r_valid;
    logic [DATA_BITS-1:0]  r_data;
    logic [2:0]            r_ch;
    logic                  r_overrun;
    logic                  w_tick;
    logic                  w_start;
    logic                  w_frame_end;
    logic                  w_produce;
    logic                  w_ovr_set;
    logic [2:0]            w_pick;
    logic [FRAME_BITS-1:0] w_din_word;

    adc_rr_pick u_rr_pick (
        .i_mask (ch_mask),
        .i_last (r_last_addr),
        .o_next (w_pick)
    );

    assign w_tick      = (r_div == DIV_LAST);
    assign w_start     = (r_state == IDLE) && trigger && (ch_mask != '0);
    assign w_frame_end = (r_state == HOLD) && w_tick;
    assign w_produce   = w_frame_end && r_primed;
    assign w_ovr_set   = (trigger && (r_state != IDLE)) || (w_produce && r_valid && !sample_ready);
    assign w_din_word  = {{(FRAME_BITS - 1 - ADDR_HI){1'b0}}, r_next_addr, {ADDR_LO{1'b0}}};

    assign sample_valid = r_valid;
    assign sample_data  = r_data;
    assign sample_ch    = r_ch;
    assign overrun      = r_overrun;

    // Two-flop synchronizer for the ADC's data line
    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            r_dout_s1 <= 1'b0;
            r_dout_s2 <= 1'b0;
        end else begin
            r_dout_s1 <= adc_dout;
            r_dout_s2 <= r_dout_s1;
        end
    end

    // Half-period divider; parked at zero in IDLE so SETUP always starts a full half
    always_ff @(posedge clk_clk) begin
        if (!reset_n || r_state == IDLE || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)                          w_state_nxt = SETUP;
            SETUP:   if (w_tick)                           w_state_nxt = SHIFT;
            SHIFT:   if (w_tick && r_half == HALF_LAST)    w_state_nxt = HOLD;
            HOLD:    if (w_tick)                           w_state_nxt = GUARD;
            GUARD:   if (w_tick)                           w_state_nxt = IDLE;
            default:                                       w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs; r_half is frozen through HOLD so only one register moves per SCLK/DIN edge
    always_comb begin
        adc_cs_n = 1'b1;
        adc_sclk = 1'b1;
        adc_din  = 1'b0;
        busy     = (r_state != IDLE);
        case (r_state)
            SETUP, HOLD: adc_cs_n = 1'b0;
            SHIFT: begin
                adc_cs_n = 1'b0;
                adc_sclk = r_half[0];
                adc_din  = w_din_word[4'(FRAME_BITS - 1) - r_half[4:1]];
            end
            default: ;
        endcase
    end

    // Half-cycle index within SHIFT: even = SCLK low, odd = SCLK high
    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            r_half <= '0;
        end else if (r_state == SHIFT) begin
            if (w_tick && r_half != HALF_LAST) begin
                r_half <= r_half + 5'd1;
            end
        end else if (r_state != HOLD) begin
            r_half <= '0;
        end
    end

    // Capture DOUT on each SCLK rise; the four leading zeros fall off the top
    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            r_shift <= '0;
        end else if (r_state == SHIFT && w_tick && !r_half[0]) begin
            r_shift <= {r_shift[DATA_BITS-2:0], r_dout_s2};
        end
    end

    // Address pipeline: this frame's data belongs to the address sent last frame
    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            r_next_addr <= 3'd0;
            r_last_addr <= 3'd7;
            r_primed    <= 1'b0;
        end else begin
            if (w_start) begin
                r_next_addr <= w_pick;
            end
            if (w_frame_end) begin
                r_last_addr <= r_next_addr;
                r_primed    <= 1'b1;
            end
        end
    end

    // Sample holding register; a full, unaccepted register keeps its sample and the new one is dropped
    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= 3'd0;
        end else if (w_produce && !(r_valid && !sample_ready)) begin
            r_valid <= 1'b1;
            r_data  <= r_shift;
            r_ch    <= r_last_addr;
        end else if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new event outranks a same-cycle clear
    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

endmodule
